// File: rtl/counter_pkg.sv
// Shared constants for the board timers, plus a clog2 helper for
// elaboration-time width checks.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEFAULT_PRESCALE = 50_000_000;

  // Bits needed to hold values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/prescaled_updown_counter_if.sv
// Switch/button inputs and display outputs of the prescaled up/down counter.
interface prescaled_updown_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             dir;
  logic             pushbutton;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic             tc;

  modport master (output en, dir, pushbutton, set, input q, tick, tc);
  modport slave  (input en, dir, pushbutton, set, output q, tick, tc);
endinterface

// File: rtl/tick_prescaler.sv
// Free-running down-counting prescaler; step is a combinational strobe for
// the enabled cycle on which the count reaches zero.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int PS_WIDTH = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic step
);

  if (PRESCALE < 1 || clog2(PRESCALE) > PS_WIDTH) begin : g_bad_param
    $error("tick_prescaler: PS_WIDTH too small for PRESCALE, or PRESCALE < 1");
  end

  localparam logic [PS_WIDTH-1:0] RELOAD = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] r_ps_cnt;
  logic                w_zero;

  assign w_zero = (r_ps_cnt == '0);
  // A restart swallows a coincident step so the load owns that edge.
  assign step   = en && w_zero && !restart;

  always_ff @(posedge clk) begin
    if (reset)        r_ps_cnt <= RELOAD;
    else if (restart) r_ps_cnt <= RELOAD;
    else if (en) begin
      if (w_zero) r_ps_cnt <= RELOAD;
      else        r_ps_cnt <= r_ps_cnt - PS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down counter with wrap/saturate and a synchronised,
// edge-detected push-button load of the set switches.
module prescaled_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter int PRESCALE  = DEFAULT_PRESCALE,
  parameter int PS_WIDTH  = 26,
  parameter bit SATURATE  = 1'b0
) (
  input logic                         clk,
  input logic                         reset,
  prescaled_updown_counter_if.slave   cnt_if
);

  if (MAX_VALUE < 1 || MAX_VALUE > 2**WIDTH - 1) begin : g_bad_max
    $error("prescaled_updown_counter: MAX_VALUE out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] r_q;
  logic             r_tick;
  logic             r_tc;
  logic [1:0]       r_pb_sync;
  logic             r_pb_prev;

  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_set_cl;

  assign w_load   = r_pb_sync[1] && !r_pb_prev;
  assign w_set_cl = (cnt_if.set > MAX_Q) ? MAX_Q : cnt_if.set;

  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_WIDTH (PS_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (cnt_if.en),
    .restart (w_load),
    .step    (w_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      r_tick    <= 1'b0;
      r_tc      <= 1'b0;
      r_pb_sync <= '0;
      r_pb_prev <= 1'b0;
    end else begin
      r_pb_sync <= {r_pb_sync[0], cnt_if.pushbutton};
      r_pb_prev <= r_pb_sync[1];
      r_tick    <= 1'b0;
      r_tc      <= 1'b0;
      if (w_load) begin
        r_q <= w_set_cl;
      end else if (w_step) begin
        r_tick <= 1'b1;
        if (cnt_if.dir == DIR_UP) begin
          if (r_q >= MAX_Q) begin
            r_tc <= 1'b1;
            r_q  <= SATURATE ? MAX_Q : '0;
          end else begin
            r_q  <= r_q + WIDTH'(1);
          end
        end else begin
          if (r_q == '0) begin
            r_tc <= 1'b1;
            r_q  <= SATURATE ? '0 : MAX_Q;
          end else begin
            r_q  <= r_q - WIDTH'(1);
          end
        end
      end
    end
  end

  assign cnt_if.q    = r_q;
  assign cnt_if.tick = r_tick;
  assign cnt_if.tc   = r_tc;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Drives three builds (wrap/15, saturate/15, wrap/9) with shared stimulus and
// checks every cycle against an event-level reference model.
module tb_prescaled_updown_counter;

  localparam int W  = 4;
  localparam int PS = 4;
  localparam int NB = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, dir, pb;
  logic [W-1:0] set;

  always #5 clk = ~clk;

  prescaled_updown_counter_if #(.WIDTH(W)) if0 ();
  prescaled_updown_counter_if #(.WIDTH(W)) if1 ();
  prescaled_updown_counter_if #(.WIDTH(W)) if2 ();

  assign if0.en = en; assign if0.dir = dir; assign if0.pushbutton = pb; assign if0.set = set;
  assign if1.en = en; assign if1.dir = dir; assign if1.pushbutton = pb; assign if1.set = set;
  assign if2.en = en; assign if2.dir = dir; assign if2.pushbutton = pb; assign if2.set = set;

  prescaled_updown_counter #(.WIDTH(W), .MAX_VALUE(15), .PRESCALE(PS), .PS_WIDTH(3), .SATURATE(1'b0))
    dut_wrap (.clk(clk), .reset(reset), .cnt_if(if0));
  prescaled_updown_counter #(.WIDTH(W), .MAX_VALUE(15), .PRESCALE(PS), .PS_WIDTH(3), .SATURATE(1'b1))
    dut_sat  (.clk(clk), .reset(reset), .cnt_if(if1));
  prescaled_updown_counter #(.WIDTH(W), .MAX_VALUE(9),  .PRESCALE(PS), .PS_WIDTH(3), .SATURATE(1'b0))
    dut_m9   (.clk(clk), .reset(reset), .cnt_if(if2));

  logic [W-1:0] q_o   [NB];
  logic         tick_o[NB];
  logic         tc_o  [NB];
  assign q_o[0] = if0.q; assign tick_o[0] = if0.tick; assign tc_o[0] = if0.tc;
  assign q_o[1] = if1.q; assign tick_o[1] = if1.tick; assign tc_o[1] = if1.tc;
  assign q_o[2] = if2.q; assign tick_o[2] = if2.tick; assign tc_o[2] = if2.tc;

  // Reference: build limits, counts, and elapsed enabled cycles in the period.
  int maxv [NB] = '{15, 15, 9};
  bit satm [NB] = '{0, 1, 0};
  int mq   [NB];
  bit mtick[NB];
  bit mtc  [NB];
  int elapsed;
  bit pb_hist[3];   // pushbutton as sampled 1, 2 and 3 edges ago

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int b);
    mtick[b] = 1'b1;
    if (dir == 1'b0) begin
      if (mq[b] == maxv[b]) begin mtc[b] = 1'b1; if (!satm[b]) mq[b] = 0; end
      else mq[b] = mq[b] + 1;
    end else begin
      if (mq[b] == 0) begin mtc[b] = 1'b1; if (!satm[b]) mq[b] = maxv[b]; end
      else mq[b] = mq[b] - 1;
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all builds shortly after.
  task automatic cyc();
    bit ld;
    @(posedge clk);
    if (reset) begin
      for (int b = 0; b < NB; b++) begin mq[b] = 0; mtick[b] = 0; mtc[b] = 0; end
      elapsed = 0;
      pb_hist = '{0, 0, 0};
    end else begin
      ld = pb_hist[1] && !pb_hist[2];
      pb_hist[2] = pb_hist[1];
      pb_hist[1] = pb_hist[0];
      pb_hist[0] = pb;
      for (int b = 0; b < NB; b++) begin mtick[b] = 0; mtc[b] = 0; end
      if (ld) begin
        for (int b = 0; b < NB; b++) mq[b] = (int'(set) > maxv[b]) ? maxv[b] : int'(set);
        elapsed = 0;
      end else if (en) begin
        if (elapsed == PS - 1) begin
          elapsed = 0;
          for (int b = 0; b < NB; b++) model_step(b);
        end else begin
          elapsed++;
        end
      end
    end
    #1;
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("q[%0d]", b),    int'(q_o[b]),    mq[b]);
      chk($sformatf("tick[%0d]", b), int'(tick_o[b]), int'(mtick[b]));
      chk($sformatf("tc[%0d]", b),   int'(tc_o[b]),   int'(mtc[b]));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input logic [W-1:0] v, input int hold);
    set = v; pb = 1'b1; run(hold);
    pb = 1'b0; run(2);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; dir = 1'b0; pb = 1'b0; set = '0;
    elapsed = 0;
    pb_hist = '{0, 0, 0};
    run(2);
    chk("rst_q", int'(q_o[0]), 0);
    chk("rst_tick", int'(tick_o[0]), 0);

    // Count up; first step on the 4th edge after reset drops.
    reset = 1'b0;
    run(4);
    chk("first_step_q", int'(q_o[0]), 1);
    chk("first_step_tick", int'(tick_o[0]), 1);
    run(8);

    // Load 15, count up through the boundary.
    press(4'd15, 4); run(10);
    // Load 0, count down through the boundary; then clamp check with 12.
    dir = 1'b1; press(4'd0, 3); run(10);
    press(4'd12, 3);
    chk("clamp_m9", int'(q_o[2]), 9);
    chk("load12_wrap", int'(q_o[0]), 12);
    run(6);

    // Held button loads once, then counts on.
    dir = 1'b0; set = 4'd7; pb = 1'b1;
    run(3);
    chk("held_load_q", int'(q_o[0]), 7);
    run(17); pb = 1'b0; run(10);

    // Load edge coinciding with the prescaler's step edge.
    reset = 1'b1; run(1); reset = 1'b0;
    set = 4'd5; run(1);
    pb = 1'b1; run(3);
    chk("coinc_q", int'(q_o[0]), 5);
    chk("coinc_tick", int'(tick_o[0]), 0);
    pb = 1'b0; run(9);

    // Reset mid-period, then freeze with en=0.
    run(2); reset = 1'b1; run(1); reset = 1'b0; run(6);
    en = 1'b0; run(10); en = 1'b1; run(6);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) pb = ~pb;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      en    = ($urandom_range(0, 7) != 0);
      set   = W'($urandom_range(0, 15));
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
